// File: rtl/uart_rx_cmd_if.sv
// Serial line and command outputs of the host UART receiver.
// The receiver uses the slave modport; the host/consumer side uses master.
interface uart_rx_cmd_if;
  logic       rx;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input cmd, cmd_valid, frame_err, busy);
  modport slave  (input rx, output cmd, cmd_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver producing the ASCII command byte for the waveform selector.
// Oversampled bit timing; cmd holds the last good byte, strobes are one cycle wide.
module uart_rx_cmd #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_cmd_if.slave   bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_rx_cmd: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("uart_rx_cmd: OVERSAMPLE must be even and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic              rx_m, rx_s, rx_d;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [OS_W-1:0]   smp_cnt, smp_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic [7:0]        cmd_q, cmd_n;
  logic              valid_q, valid_n;
  logic              err_q, err_n;
  logic              busy_q, busy_n;
  logic              tick;
  logic              fall;

  // Sync FFs and edge FF reset low, so a start needs the line to be seen high first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_d <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign tick = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      smp_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      smp_cnt <= smp_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      cmd_q   <= cmd_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    smp_n   = smp_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    cmd_n   = cmd_q;
    valid_n = 1'b0;
    err_n   = 1'b0;

    if (state != IDLE) div_n = tick ? '0 : div_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          smp_n   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (smp_cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
            smp_n   = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (smp_cnt == OS_W'(OVERSAMPLE - 1)) begin
            smp_n   = '0;
            shift_n = {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_n   = bit_idx + 1'b1;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start.
        if (tick) begin
          if (smp_cnt == OS_W'(OVERSAMPLE - 1)) begin
            smp_n   = '0;
            state_n = IDLE;
            if (rx_s) begin
              cmd_n   = shift;
              valid_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if ((state_n == IDLE) || (state == IDLE)) div_n = '0;
    busy_n = (state_n != IDLE);
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;

endmodule
